// File: rtl/watchdog_supervisor_pkg.sv
// watchdog_supervisor shared types.
// FSM encoding, cfg bit indices and sts field map.
package watchdog_supervisor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_HOLD     = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

  localparam int CFG_TGL_EN   = 0;
  localparam int CFG_ACK_EN   = 1;
  localparam int CFG_ALIVE_EN = 2;
  localparam int CFG_AUTO_RST = 3;
  localparam int CFG_CLR      = 4;
  localparam int CFG_MAN_RST  = 5;

  localparam int STS_WD        = 0;
  localparam int STS_ACK_S     = 1;
  localparam int STS_ALIVE_S   = 2;
  localparam int STS_ACK_FLT   = 3;
  localparam int STS_ALIVE_FLT = 4;
  localparam int STS_IRST      = 5;
  localparam int STS_STATE     = 6;
  localparam int STS_STATE_W   = 2;
  localparam int STS_FCNT      = 8;
  localparam int STS_FCNT_W    = 8;
  localparam int STS_LAT       = 16;
  localparam int STS_LAT_W     = 16;

endpackage

// File: rtl/bit_synchronizer.sv
// N-stage bit synchronizer with a rising-edge output.
// STAGES=0 passes the input through; edge uses a registered copy.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise
);

  logic r_prev;

  generate
    if (STAGES == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_sync
      logic [STAGES-1:0] r_sync;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= i_d;
          for (int i = 1; i < STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign o_q = r_sync[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= o_q;
    end
  end

  assign o_rise = o_q & ~r_prev;

endmodule

// File: rtl/watchdog_supervisor.sv
// Controller-side watchdog: toggles the line, checks the echo,
// watches the alive heartbeat and drives instant reset on faults.
module watchdog_supervisor
  import watchdog_supervisor_pkg::*;
#(
  parameter int TOGGLE_PERIOD_CYCLES = 3125000,
  parameter int ACK_TIMEOUT_CYCLES   = 125000,
  parameter int ALIVE_TIMEOUT_CYCLES = 18750000
) (
  input  logic        clk,
  input  logic        peripheral_aresetn,
  input  logic [7:0]  cfg,
  output logic        watchdog_out,
  input  logic        reset_ack_in,
  input  logic        alive_signal_in,
  output logic        instant_reset_out,
  output logic        fault_irq,
  output logic [31:0] sts
);

  localparam int PW =
    (TOGGLE_PERIOD_CYCLES > 1) ? $clog2(TOGGLE_PERIOD_CYCLES) : 1;
  localparam logic [PW-1:0] P_LAST =
    PW'(TOGGLE_PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] P_ACK_TO = PW'(ACK_TIMEOUT_CYCLES);
  localparam logic [27:0] A_TO = 28'(ALIVE_TIMEOUT_CYCLES);

  state_e        r_state;
  state_e        w_next;
  logic          r_wd;
  logic [PW-1:0] r_pcnt;
  logic [15:0]   r_lat;
  logic [7:0]    r_fcnt;
  logic [27:0]   r_acnt;
  logic          r_ack_fault;
  logic          r_alive_fault;
  logic          r_ack_fault_d;
  logic          r_alive_fault_d;
  logic          r_irq;
  logic          r_irst;
  logic          r_cfg2_d;

  logic          w_ack_s;
  logic          w_alive_s;
  logic          w_alive_rise;
  logic          w_clr;
  logic          w_toggle;
  logic          w_pinc;
  logic          w_ack_ok;
  logic          w_ack_to;
  logic          w_alive_to;
  logic          w_cfg2_rise;
  logic [31:0]   w_pcnt_ext;
  logic [15:0]   w_lat_sat;
  logic [31:0]   w_sts;
  logic          w_ack_rise_unused;
  logic          w_clr_lvl_unused;
  logic          w_cfg_unused;

  bit_synchronizer #(.STAGES(2)) u_ack_sync (
    .clk    (clk),
    .rst_n  (peripheral_aresetn),
    .i_d    (reset_ack_in),
    .o_q    (w_ack_s),
    .o_rise (w_ack_rise_unused)
  );

  bit_synchronizer #(.STAGES(2)) u_alive_sync (
    .clk    (clk),
    .rst_n  (peripheral_aresetn),
    .i_d    (alive_signal_in),
    .o_q    (w_alive_s),
    .o_rise (w_alive_rise)
  );

  bit_synchronizer #(.STAGES(0)) u_clr_edge (
    .clk    (clk),
    .rst_n  (peripheral_aresetn),
    .i_d    (cfg[CFG_CLR]),
    .o_q    (w_clr_lvl_unused),
    .o_rise (w_clr)
  );

  assign w_cfg_unused = &{1'b0, cfg[7:6]};
  assign w_cfg2_rise  = cfg[CFG_ALIVE_EN] & ~r_cfg2_d;
  assign w_alive_to   = cfg[CFG_ALIVE_EN] && (r_acnt == A_TO);
  assign w_pcnt_ext   = 32'(r_pcnt);
  assign w_lat_sat    = (w_pcnt_ext > 32'd65535) ?
                        16'hFFFF : w_pcnt_ext[15:0];

  always_comb begin
    w_next   = r_state;
    w_toggle = 1'b0;
    w_pinc   = 1'b0;
    w_ack_ok = 1'b0;
    w_ack_to = 1'b0;
    if (!cfg[CFG_TGL_EN]) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_toggle = 1'b1;
          w_next   = cfg[CFG_ACK_EN] ? ST_WAIT_ACK : ST_HOLD;
        end
        ST_WAIT_ACK: begin
          if (w_ack_s == r_wd) begin
            w_ack_ok = 1'b1;
            w_pinc   = 1'b1;
            w_next   = ST_HOLD;
          end else if (r_pcnt == P_ACK_TO) begin
            w_ack_to = 1'b1;
            w_next   = ST_FAULT;
          end else begin
            w_pinc = 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_pcnt == P_LAST) begin
            w_toggle = 1'b1;
            w_next   = cfg[CFG_ACK_EN] ? ST_WAIT_ACK : ST_HOLD;
          end else begin
            w_pinc = 1'b1;
          end
        end
        ST_FAULT: begin
          if (w_clr) begin
            w_next = ST_IDLE;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      r_state <= ST_IDLE;
      r_wd    <= 1'b0;
      r_pcnt  <= '0;
      r_lat   <= '0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_toggle) begin
        r_wd   <= ~r_wd;
        r_pcnt <= '0;
      end else if (w_pinc) begin
        r_pcnt <= r_pcnt + PW'(1);
      end
      if (w_ack_ok) begin
        r_lat <= w_lat_sat;
      end
      if (w_ack_to && (r_fcnt != 8'hFF)) begin
        r_fcnt <= r_fcnt + 8'd1;
      end
    end
  end

  // Fault set has priority over a clear arriving on the same edge.
  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      r_ack_fault   <= 1'b0;
      r_alive_fault <= 1'b0;
      r_acnt        <= '0;
      r_cfg2_d      <= 1'b0;
    end else begin
      r_cfg2_d <= cfg[CFG_ALIVE_EN];
      if (w_ack_to) begin
        r_ack_fault <= 1'b1;
      end else if (w_clr) begin
        r_ack_fault <= 1'b0;
      end
      if (w_alive_to) begin
        r_alive_fault <= 1'b1;
      end else if (w_clr) begin
        r_alive_fault <= 1'b0;
      end
      if (w_alive_rise || w_clr || w_cfg2_rise) begin
        r_acnt <= '0;
      end else if (r_acnt != '1) begin
        r_acnt <= r_acnt + 28'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      r_ack_fault_d   <= 1'b0;
      r_alive_fault_d <= 1'b0;
      r_irq           <= 1'b0;
      r_irst          <= 1'b0;
    end else begin
      r_ack_fault_d   <= r_ack_fault;
      r_alive_fault_d <= r_alive_fault;
      r_irq  <= (r_ack_fault & ~r_ack_fault_d) |
                (r_alive_fault & ~r_alive_fault_d);
      r_irst <= cfg[CFG_MAN_RST] |
                (cfg[CFG_AUTO_RST] & (r_ack_fault | r_alive_fault));
    end
  end

  always_comb begin
    w_sts                                  = '0;
    w_sts[STS_WD]                          = r_wd;
    w_sts[STS_ACK_S]                       = w_ack_s;
    w_sts[STS_ALIVE_S]                     = w_alive_s;
    w_sts[STS_ACK_FLT]                     = r_ack_fault;
    w_sts[STS_ALIVE_FLT]                   = r_alive_fault;
    w_sts[STS_IRST]                        = r_irst;
    w_sts[STS_STATE +: STS_STATE_W]        = r_state;
    w_sts[STS_FCNT +: STS_FCNT_W]          = r_fcnt;
    w_sts[STS_LAT +: STS_LAT_W]            = r_lat;
  end

  assign sts               = w_sts;
  assign watchdog_out      = r_wd;
  assign instant_reset_out = r_irst;
  assign fault_irq         = r_irq;

endmodule

// File: tb/tb_watchdog_supervisor.sv
// Self-checking bench for watchdog_supervisor.
// Remote board modelled as a delayed echo of the watchdog line.
module tb_watchdog_supervisor;

  localparam int TP = 20;
  localparam int AT = 8;
  localparam int LT = 50;

  localparam int F_WD  = 0;
  localparam int F_ALS = 2;
  localparam int F_AF  = 3;
  localparam int F_LF  = 4;
  localparam int F_ST  = 6;
  localparam int F_CNT = 8;
  localparam int F_LAT = 16;
  localparam int F_IRQ = 33;
  localparam int F_IR  = 34;

  logic        clk;
  logic        rst_n;
  logic [7:0]  cfg;
  logic        wd;
  logic        ack_in;
  logic        alive_in;
  logic        ir;
  logic        irq;
  logic [31:0] sts;
  logic [15:0] hist = '0;
  logic [3:0]  ack_dly;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    string name;
    int    cyc;
    int    lsb;
    int    w;
    int    val;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [7:0] cfg;
    int         dly;
    int         lat;
    bit         flt;
  } vec_t;
  vec_t vt[6];

  watchdog_supervisor #(
    .TOGGLE_PERIOD_CYCLES (TP),
    .ACK_TIMEOUT_CYCLES   (AT),
    .ALIVE_TIMEOUT_CYCLES (LT)
  ) dut (
    .clk                (clk),
    .peripheral_aresetn (rst_n),
    .cfg                (cfg),
    .watchdog_out       (wd),
    .reset_ack_in       (ack_in),
    .alive_signal_in    (alive_in),
    .instant_reset_out  (ir),
    .fault_irq          (irq),
    .sts                (sts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) hist <= {hist[14:0], wd};
  assign ack_in = (ack_dly == 4'd0) ? wd : hist[ack_dly - 4'd1];

  function automatic int fld(int lsb, int w);
    logic [34:0] o;
    o = {ir, irq, wd, sts};
    return int'((o >> lsb) & ((35'd1 << w) - 35'd1));
  endfunction

  task automatic chk(string n, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s @%0d: got %0d want %0d", n, cyc, got, want);
    end
  endtask

  task automatic expect_at(string n, int c, int lsb, int w, int v);
    exp_t e;
    e.name = n;
    e.cyc  = c;
    e.lsb  = lsb;
    e.w    = w;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        chk(q[i].name, fld(q[i].lsb, q[i].w), q[i].val);
        q.delete(i);
      end
    end
  endtask

  task automatic run_to(int c);
    while (cyc < c) tick();
  endtask

  task automatic flush();
    while (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s: never compared, want %0d at %0d",
               q[0].name, q[0].val, q[0].cyc);
      void'(q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    cfg      = 8'h00;
    ack_dly  = 4'd0;
    alive_in = 1'b0;
    #1;
    chk("rst_sts", int'(sts), 0);
    chk("rst_outs", int'({ir, irq, wd}), 0);
    repeat (20) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200us;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    int c;
    int x;
    int last;
    int n;
    logic prev;

    rst_n = 1'b0;
    vt[0] = '{8'h03, 0, 2, 1'b0};
    vt[1] = '{8'h03, 3, 5, 1'b0};
    vt[2] = '{8'h03, 5, 7, 1'b0};
    vt[3] = '{8'h03, 6, 8, 1'b0};
    vt[4] = '{8'h03, 9, 0, 1'b1};
    vt[5] = '{8'h0B, 9, 0, 1'b1};

    foreach (vt[k]) begin
      do_reset();
      ack_dly = 4'(vt[k].dly);
      cfg     = vt[k].cfg;
      t0      = cyc + 1;
      expect_at("v_tgl", t0, F_WD, 1, 1);
      expect_at("v_wait", t0, F_ST, 2, 1);
      if (!vt[k].flt) begin
        expect_at("v_prehold", t0 + vt[k].lat, F_ST, 2, 1);
        expect_at("v_hold", t0 + vt[k].lat + 1, F_ST, 2, 2);
        expect_at("v_lat", t0 + vt[k].lat + 1, F_LAT, 16, vt[k].lat);
        expect_at("v_wd_pre", t0 + TP - 1, F_WD, 1, 1);
        expect_at("v_wd_tgl", t0 + TP, F_WD, 1, 0);
        expect_at("v_rewait", t0 + TP + 1, F_ST, 2, 1);
        expect_at("v_nofault", t0 + TP + 2, F_AF, 2, 0);
      end else begin
        expect_at("f_prefault", t0 + AT, F_ST, 2, 1);
        expect_at("f_state", t0 + AT + 1, F_ST, 2, 3);
        expect_at("f_flag", t0 + AT + 1, F_AF, 1, 1);
        expect_at("f_cnt", t0 + AT + 1, F_CNT, 8, 1);
        expect_at("f_irq_pre", t0 + AT + 1, F_IRQ, 1, 0);
        expect_at("f_ir_pre", t0 + AT + 1, F_IR, 1, 0);
        expect_at("f_irq", t0 + AT + 2, F_IRQ, 1, 1);
        expect_at("f_ir", t0 + AT + 2, F_IR, 1, int'(vt[k].cfg[3]));
        expect_at("f_irq_end", t0 + AT + 3, F_IRQ, 1, 0);
        expect_at("f_frozen", t0 + 25, F_WD, 1, 1);
        expect_at("f_stay", t0 + 25, F_ST, 2, 3);
      end
      run_to(t0 + 26);
      flush();
    end

    // Clear pulse out of the last (auto-reset) fault; toggling resumes.
    ack_dly = 4'd0;
    cfg     = 8'h1B;
    c       = cyc + 1;
    expect_at("clr_flag", c, F_AF, 1, 0);
    expect_at("clr_idle", c, F_ST, 2, 0);
    expect_at("clr_cnt", c, F_CNT, 8, 1);
    expect_at("clr_ir_hold", c, F_IR, 1, 1);
    expect_at("clr_ir_fall", c + 1, F_IR, 1, 0);
    expect_at("clr_tgl", c + 1, F_WD, 1, 0);
    expect_at("clr_wait", c + 1, F_ST, 2, 1);
    expect_at("clr_hold", c + 4, F_ST, 2, 2);
    expect_at("clr_wd_pre", c + TP, F_WD, 1, 0);
    expect_at("clr_wd_tgl", c + TP + 1, F_WD, 1, 1);
    run_to(c + TP + 2);
    cfg = 8'h0B;
    flush();

    // Loopback over ten periods.
    do_reset();
    cfg = 8'h03;
    tick();
    chk("lb_first", int'(wd), 1);
    last = cyc;
    prev = wd;
    for (int p = 0; p < 10; p++) begin
      n = 0;
      while (wd == prev && n < TP + 5) begin
        tick();
        n++;
      end
      chk("lb_period", cyc - last, TP);
      chk("lb_lat", fld(F_LAT, 16), 2);
      chk("lb_nofault", fld(F_AF, 2), 0);
      last = cyc;
      prev = wd;
    end

    // Alive heartbeat every 40 cycles, then silence.
    do_reset();
    cfg = 8'h04;
    x   = cyc;
    for (int k = 0; k < 4; k++) begin
      alive_in = 1'b1;
      x = cyc;
      expect_at("al_ok", x + 39, F_LF, 1, 0);
      if (k == 3) begin
        expect_at("al_sync_lo", x + 1, F_ALS, 1, 0);
        expect_at("al_sync_hi", x + 2, F_ALS, 1, 1);
        // acnt cleared at x+3, equals LT at x+3+LT, flag on the next edge
        expect_at("al_pre", x + LT + 3, F_LF, 1, 0);
        expect_at("al_fault", x + LT + 4, F_LF, 1, 1);
        expect_at("al_irq", x + LT + 5, F_IRQ, 1, 1);
        expect_at("al_irq_end", x + LT + 6, F_IRQ, 1, 0);
        expect_at("al_no_ir", x + LT + 6, F_IR, 1, 0);
        expect_at("al_idle", x + LT + 4, F_ST, 2, 0);
      end
      repeat (5) tick();
      alive_in = 1'b0;
      repeat (35) tick();
    end
    run_to(x + LT + 8);
    flush();

    // Timeout and clear edge in the same cycle.
    do_reset();
    ack_dly = 4'd9;
    cfg     = 8'h03;
    t0      = cyc + 1;
    run_to(t0 + AT);
    cfg = 8'h13;
    expect_at("tc_state", t0 + AT + 1, F_ST, 2, 3);
    expect_at("tc_flag", t0 + AT + 1, F_AF, 1, 1);
    expect_at("tc_cnt", t0 + AT + 1, F_CNT, 8, 1);
    expect_at("tc_state2", t0 + AT + 4, F_ST, 2, 3);
    expect_at("tc_flag2", t0 + AT + 4, F_AF, 1, 1);
    run_to(t0 + AT + 5);
    cfg = 8'h03;
    tick();
    cfg = 8'h13;
    c   = cyc + 1;
    expect_at("tc_clr_idle", c, F_ST, 2, 0);
    expect_at("tc_clr_flag", c, F_AF, 1, 0);
    run_to(c + 1);
    flush();

    // Toggle enable dropped while waiting for the echo.
    do_reset();
    ack_dly = 4'd9;
    cfg     = 8'h03;
    t0      = cyc + 1;
    run_to(t0 + 3);
    cfg = 8'h02;
    expect_at("dis_idle", t0 + 4, F_ST, 2, 0);
    expect_at("dis_wd", t0 + 4, F_WD, 1, 1);
    expect_at("dis_idle2", t0 + 12, F_ST, 2, 0);
    expect_at("dis_wd2", t0 + 12, F_WD, 1, 1);
    expect_at("dis_noflt", t0 + 12, F_AF, 1, 0);
    expect_at("dis_nocnt", t0 + 12, F_CNT, 8, 0);
    run_to(t0 + 13);
    flush();

    // Manual reset, then asynchronous reset in HOLD.
    do_reset();
    cfg = 8'h23;
    t0  = cyc + 1;
    expect_at("man_ir", t0, F_IR, 1, 1);
    expect_at("ar_hold", t0 + 4, F_ST, 2, 2);
    expect_at("ar_hold2", t0 + 10, F_ST, 2, 2);
    run_to(t0 + 10);
    flush();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_sts", int'(sts), 0);
    chk("ar_outs", int'({ir, irq, wd}), 0);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/watchdog_supervisor.md
# watchdog_supervisor

Controller-side counterpart of the per-board reset manager. It toggles the `watchdog` line at a fixed period and checks that the remote board echoes each toggle on `reset_ack` within a timeout. It also watches the remote `alive_signal` heartbeat and can drive `instant_reset` on a fault, either automatically or on software command. It sits in the PL next to the PS configuration/status registers and drives the daisy-chain I/O pins through the usual IOBUF wrappers.

## Interface
- `TOGGLE_PERIOD_CYCLES`, default 3125000: clk cycles between consecutive `watchdog_out` toggles (25 ms at 125 MHz).
- `ACK_TIMEOUT_CYCLES`, default 125000: maximum cycles from a toggle to a matching synchronized `reset_ack`. Must be < `TOGGLE_PERIOD_CYCLES`.
- `ALIVE_TIMEOUT_CYCLES`, default 18750000: maximum cycles between `alive_signal` rising edges (150 ms; the remote period is 110 ms).
- `clk` input 1: single clock, 125 MHz.
- `peripheral_aresetn` input 1: asynchronous, active-low reset.
- `cfg` input 8:
  - bit0 toggle enable
  - bit1 ack check enable
  - bit2 alive check enable
  - bit3 auto instant reset on fault
  - bit4 fault clear (acts on the rising edge)
  - bit5 manual instant reset
  - bits 7:6 reserved
- `watchdog_out` output 1: watchdog toggle line to the remote board.
- `reset_ack_in` input 1: asynchronous echo of `watchdog` from the remote board.
- `alive_signal_in` input 1: asynchronous remote heartbeat.
- `instant_reset_out` output 1: instant reset request to the remote board.
- `fault_irq` output 1: one-cycle pulse on any new fault.
- `sts` output 32: status word, fields listed under Operation.

## Operation
- Inputs: `reset_ack_in` and `alive_signal_in` each pass through 2-flop synchronizers giving `ack_s` and `alive_s`. `alive_s` gets a registered rising-edge detect. `cfg[4]` gets a registered rising-edge detect (`clr`).
- Period counter `pcnt`, width clog2(`TOGGLE_PERIOD_CYCLES`):
  - cleared on every toggle, increments in WAIT_ACK and HOLD.
- FSM states: IDLE, WAIT_ACK, HOLD, FAULT.
  - IDLE: `watchdog_out` held.
    - `cfg[0]`=1: toggle on the next edge, clear `pcnt`.
    - Go to WAIT_ACK if `cfg[1]`=1, else HOLD.
  - WAIT_ACK:
    - If `ack_s`==`watchdog_out`: go to HOLD, `sts[31:16]` ← min(`pcnt`, 65535).
    - Else if `pcnt`==`ACK_TIMEOUT_CYCLES`: go to FAULT, set `ack_fault`, fault count +1 (saturates at 255).
    - Match and timeout in the same cycle: match wins.
  - HOLD: when `pcnt`==`TOGGLE_PERIOD_CYCLES`-1, toggle, clear `pcnt`, go to WAIT_ACK (or stay in HOLD if `cfg[1]`=0).
  - FAULT: `watchdog_out` frozen, deliberately starving the remote watchdog. Leave on `clr` → IDLE.
  - Any state with `cfg[0]`=0 → IDLE on the next edge. `watchdog_out` keeps its level; sticky faults are kept.
- Alive monitor: counter `acnt`, 28 bits, saturating.
  - Cleared on an alive rising edge, on `clr`, and on the 0→1 edge of `cfg[2]`.
  - `cfg[2]`=1 and `acnt`==`ALIVE_TIMEOUT_CYCLES` → set `alive_fault`.
- Faults `ack_fault` and `alive_fault` are sticky and cleared only by `clr`. Set wins over a simultaneous `clr`.
- `fault_irq`: registered pulse when either fault flag goes 0→1.
- `instant_reset_out` is registered: `cfg[5]` | (`cfg[3]` & (`ack_fault` | `alive_fault`)).
- `sts` fields:
  - [0] `watchdog_out`
  - [1] `ack_s`
  - [2] `alive_s`
  - [3] `ack_fault`
  - [4] `alive_fault`
  - [5] `instant_reset_out`
  - [7:6] state encoding: IDLE=0, WAIT_ACK=1, HOLD=2, FAULT=3
  - [15:8] ack fault count
  - [31:16] last ack latency

## Timing
- Reset (asynchronous): all outputs 0, `sts`=0, state IDLE, all counters and synchronizers 0.
- First toggle occurs on the first edge on which `cfg[0]`=1 is sampled in IDLE.
- Toggle-to-toggle spacing is exactly `TOGGLE_PERIOD_CYCLES`.
- Direct loopback (`reset_ack_in`=`watchdog_out`): recorded latency is 2 and HOLD is entered 3 edges after the toggle edge.
- Ack timeout: FAULT is entered on the edge where `pcnt` reaches `ACK_TIMEOUT_CYCLES` without a match.
- `instant_reset_out` and `fault_irq` assert 1 cycle after the fault flag is set.
- Manual reset: `instant_reset_out` follows `cfg[5]` with 1 cycle of latency.
- Alive: a rising edge on the pin affects `acnt` 3 cycles later (2 sync stages plus edge register).

## Structure
- Package `watchdog_supervisor_pkg` holds:
  - the state enum
  - `cfg` bit indices
  - `sts` field offsets and widths
- Sub-module `bit_synchronizer`: parameterized stage count, optional rising-edge output. Instanced for ack, alive and the `cfg[4]` edge.

## Test plan
Bench parameters: `TOGGLE_PERIOD_CYCLES`=20, `ACK_TIMEOUT_CYCLES`=8, `ALIVE_TIMEOUT_CYCLES`=50.
- Loopback, `cfg`=0x03 → `watchdog_out` toggles every 20 cycles, `sts[31:16]`=2, no faults for 10 periods.
- Ack delayed 5 cycles, then 9 cycles →
  - 5 cycles: latency field reads 7.
  - 9 cycles: FAULT at `pcnt`=8, `fault_irq` pulses once, count=1, `watchdog_out` frozen.
- Ack fault with `cfg`=0x0B → `instant_reset_out`=1 one cycle after the fault. Pulse `cfg[4]` → flags clear, `instant_reset_out` falls, IDLE, toggling resumes.
- Alive edges every 40 cycles with `cfg[2]`=1 → no fault. Stop the edges → `alive_fault` set exactly 50 cycles after the last `acnt` clear.
- Timeout and `clr` rising edge in the same cycle → fault stays set. `cfg[0]` dropped mid-WAIT_ACK → IDLE, `watchdog_out` unchanged.
- Assert `peripheral_aresetn` low mid-HOLD → all outputs and `sts` read 0 immediately, without waiting for a clock edge.
